// File: rtl/approx_accumulator_if.sv
// Beat-in / result-out stream bundle for the approximate accumulator.
interface approx_accumulator_if #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACC_WIDTH-1:0]   out_data;
   logic                   out_overflow;
   logic [COUNT_WIDTH-1:0] out_count;

   // Producer of beats and consumer of results
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_overflow, out_count
   );

   // The accumulator itself
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_overflow, out_count
   );
endinterface

// File: rtl/approx_accumulator.sv
// Lower-part-OR approximate adder plus the packet accumulator that uses it.

// Low bits combined by OR, upper bits ripple-added; carry-out in o_sum[WIDTH].
module loawa_adder #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned IMPRECISE_PART = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_sum
);
   localparam int unsigned HI_WIDTH = WIDTH - IMPRECISE_PART;

   logic [HI_WIDTH:0] w_hi;

   assign w_hi  = {1'b0, i_a[WIDTH-1:IMPRECISE_PART]} + {1'b0, i_b[WIDTH-1:IMPRECISE_PART]};
   assign o_sum = {w_hi, i_a[IMPRECISE_PART-1:0] | i_b[IMPRECISE_PART-1:0]};
endmodule

// Sums packets of unsigned products and hands each finished sum downstream.
module approx_accumulator #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ACC_WIDTH      = 32,
   parameter int unsigned IMPRECISE_PART = 8,
   parameter int unsigned COUNT_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   approx_accumulator_if.slave  bus
);
   typedef enum logic {ACCUM, HOLD} state_e;

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic [ACC_WIDTH-1:0]   r_acc;
   logic                   r_ovf;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_out_valid;
   logic [ACC_WIDTH-1:0]   r_out_data;
   logic                   r_out_overflow;
   logic [COUNT_WIDTH-1:0] r_out_count;

   logic [ACC_WIDTH:0]     w_sum;
   logic [ACC_WIDTH-1:0]   w_x;
   logic                   w_accept;
   logic                   w_out_fire;
   logic                   w_ovf_nxt;
   logic [COUNT_WIDTH-1:0] w_cnt_nxt;

   // Approximate sum of the running total and the zero-extended product
   assign w_x = ACC_WIDTH'(bus.in_data);

   loawa_adder #(
      .WIDTH          (ACC_WIDTH),
      .IMPRECISE_PART (IMPRECISE_PART)
   ) u_adder (
      .i_a   (r_acc),
      .i_b   (w_x),
      .o_sum (w_sum)
   );

   assign w_accept   = bus.in_valid && (r_state == ACCUM);
   assign w_out_fire = r_out_valid && bus.out_ready;
   assign w_ovf_nxt  = r_ovf | w_sum[ACC_WIDTH];
   assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + COUNT_WIDTH'(1);

   assign bus.in_ready     = (r_state == ACCUM);
   assign bus.out_valid    = r_out_valid;
   assign bus.out_data     = r_out_data;
   assign bus.out_overflow = r_out_overflow;
   assign bus.out_count    = r_out_count;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_state_nxt;
   end

   // Next state: close a packet on its last beat, reopen on output handshake
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ACCUM;
      end else begin
         case (r_state)
            ACCUM:   if (w_accept && bus.in_last) w_state_nxt = HOLD;
            HOLD:    if (w_out_fire)               w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
         endcase
      end
   end

   // Running sum, sticky carry, beat count and the result holding registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc          <= '0;
         r_ovf          <= 1'b0;
         r_cnt          <= '0;
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_out_overflow <= 1'b0;
         r_out_count    <= '0;
      end else if (clear) begin
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         if (bus.in_last) begin
            r_out_data     <= w_sum[ACC_WIDTH-1:0];
            r_out_overflow <= w_ovf_nxt;
            r_out_count    <= w_cnt_nxt;
            r_out_valid    <= 1'b1;
            r_acc          <= '0;
            r_ovf          <= 1'b0;
            r_cnt          <= '0;
         end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            r_ovf <= w_ovf_nxt;
            r_cnt <= w_cnt_nxt;
         end
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_approx_accumulator.sv
// Randomized and directed stimulus against a plain-arithmetic reference model.
module tb_approx_accumulator;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 16;
   localparam int unsigned IP = 4;
   localparam int unsigned CW = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {
      int data;
      bit ovf;
      int cnt;
   } exp_t;

   logic clk;
   logic rst;
   logic clear;
   bit   rand_ready;
   bit   fixed_ready;

   int   checks;
   int   errors;
   exp_t q[$];

   int   m_acc;
   bit   m_ovf;
   int   m_cnt;

   approx_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

   approx_accumulator #(
      .DATA_WIDTH     (DW),
      .ACC_WIDTH      (AW),
      .IMPRECISE_PART (IP),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_acc = 0;
      m_ovf = 0;
      m_cnt = 0;
   endfunction

   // Reference: low nibble is OR, the rest is an ordinary sum of the upper parts
   function automatic void model_beat(int d, bit last);
      int lo;
      int hi;
      int full;
      exp_t e;
      lo    = (m_acc | d) % (1 << IP);
      hi    = (m_acc / (1 << IP)) + (d / (1 << IP));
      full  = hi * (1 << IP) + lo;
      m_ovf = m_ovf | (full >= (1 << AW));
      m_acc = full % (1 << AW);
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (last) begin
         e.data = m_acc;
         e.ovf  = m_ovf;
         e.cnt  = m_cnt;
         q.push_back(e);
         model_reset();
      end
   endfunction

   // Single driver of out_ready: random or fixed, updated just after each edge
   always @(posedge clk) begin
      #1 bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
   end

   // Monitor: compare on every output handshake and watch stability under stall
   bit prev_hold;
   int prev_data;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && bus.out_valid)
            check("out_data_stable", int'(bus.out_data), prev_data);
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_data", int'(bus.out_data), e.data);
               check("out_overflow", int'(bus.out_overflow), int'(e.ovf));
               check("out_count", int'(bus.out_count), e.cnt);
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_data = int'(bus.out_data);
      end
   end

   task automatic send_beat(int d, bit last);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(d);
      bus.in_last  = last;
      @(posedge clk);
      model_beat(d, last);
      #1 bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic set_fixed_ready(bit v);
      rand_ready  = 1'b0;
      fixed_ready = v;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      checks       = 0;
      errors       = 0;
      rand_ready   = 1'b0;
      fixed_ready  = 1'b1;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      model_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #6;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_overflow", int'(bus.out_overflow), 0);
      check("rst_out_count", int'(bus.out_count), 0);
      @(negedge clk);
      rst = 1'b0;
      set_fixed_ready(1'b1);

      // Approximate sum 0x13 + 0x15 + 0x0A
      send_beat(8'h13, 1'b0);
      send_beat(8'h15, 1'b0);
      send_beat(8'h0A, 1'b1);

      // Back-to-back single-beat packets with the one-cycle ready gap
      send_beat(8'h40, 1'b1);
      @(negedge clk);
      check("gap_in_ready_low", int'(bus.in_ready), 0);
      @(negedge clk);
      check("gap_in_ready_high", int'(bus.in_ready), 1);
      send_beat(8'h81, 1'b1);

      // Backpressure for five cycles
      set_fixed_ready(1'b0);
      send_beat(8'h21, 1'b0);
      send_beat(8'h9C, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_in_ready", int'(bus.in_ready), 0);
      end
      fixed_ready = 1'b1;
      n = 0;
      while (!(bus.out_ready && bus.out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_release_seen", int'(bus.out_ready && bus.out_valid), 1);
      @(negedge clk);
      check("bp_in_ready_after", int'(bus.in_ready), 1);
      check("bp_out_valid_after", int'(bus.out_valid), 0);

      // Clear mid-packet; the beat presented with clear is dropped
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      @(negedge clk);
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      bus.in_last  = 1'b1;
      @(posedge clk);
      model_reset();
      #1 clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(negedge clk);
      check("clear_out_valid", int'(bus.out_valid), 0);
      send_beat(8'h07, 1'b1);

      // Clear while a result is pending discards it
      set_fixed_ready(1'b0);
      send_beat(8'h33, 1'b1);
      @(negedge clk);
      check("hold_out_valid", int'(bus.out_valid), 1);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      void'(q.pop_back());
      @(negedge clk);
      check("clear_hold_out_valid", int'(bus.out_valid), 0);
      check("clear_hold_in_ready", int'(bus.in_ready), 1);
      set_fixed_ready(1'b1);

      // Count saturation
      for (int i = 0; i < 10; i++) send_beat(8'h01, i == 9);

      // Overflow: many large beats, then a fresh small packet
      for (int i = 0; i < 300; i++) send_beat(8'hFF, i == 299);
      send_beat(8'h05, 1'b1);

      // Asynchronous reset mid-packet, after a previous nonzero result
      send_beat(8'h21, 1'b0);
      send_beat(8'h42, 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("arst_in_ready", int'(bus.in_ready), 1);
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_out_data", int'(bus.out_data), 0);
      check("arst_out_overflow", int'(bus.out_overflow), 0);
      check("arst_out_count", int'(bus.out_count), 0);
      @(negedge clk);
      rst = 1'b0;
      send_beat(8'h3C, 1'b1);

      // Random packets under random backpressure
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int len;
         len = int'($urandom_range(1, 12));
         for (int b = 0; b < len; b++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            send_beat(d, b == len - 1);
         end
      end

      // Drain remaining results
      set_fixed_ready(1'b1);
      n = 0;
      while (q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", q.size(), 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
